uart_stream_master: RTL and testbench
=====================================

# uart_stream_master

Bus-master front end that sits directly upstream of `uart_mem` and drives its register bus. After reset it programs the baud divisor. It then moves bytes from a valid/ready input stream into the UART DATA register, polling STATUS so it never overwrites a byte that is still shifting out. With the RX option it also drains received bytes into an output stream. Together the pair forms a stream-to-serial bridge that needs no CPU.

## Interface
Parameters:
- `ADDR_WIDTH`, 32, bus address width
- `DATA_WIDTH`, 32, bus data width
- `BASE_ADDR`, 0, base of the `uart_mem` register window
- `BAUD_DIV`, 434, 16-bit divisor written at init
- `POLL_GAP`, 16, idle cycles between unsuccessful STATUS polls (≥1)

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  reset; synchronous, active-high
- `s_data`  in  8  TX byte
- `s_valid`  in  1  TX byte valid; held with `s_data` stable until accepted
- `s_ready`  out  1  byte accepted when `s_valid && s_ready`
- `rx_data`  out  8  received byte (RX option)
- `rx_valid`  out  1  received byte valid (RX option)
- `rx_ready`  in  1  consumer accepts `rx_data` (RX option)
- `m_enable`  out  1  bus request
- `m_wr_en`  out  1  1 = write, 0 = read
- `m_addr`  out  ADDR_WIDTH  `BASE_ADDR` + register offset
- `m_wdata`  out  DATA_WIDTH  write data, byte in [7:0], rest 0
- `m_be`  out  4  always 4'b0001 while `m_enable` is high
- `m_ready`  in  1  slave completion
- `m_rdata`  in  DATA_WIDTH  read data, valid when `m_ready` is high
- `m_bus_err`  in  1  slave error, valid with `m_ready`
- `init_done`  out  1  high once both baud writes have completed
- `err`  out  1  sticky; set by any `m_bus_err` completion

## Operation
- Register offsets used: BAUD_L 0x0, BAUD_H 0x4, STATUS 0x8, DATA 0xC.
- STATUS bits: [0] = RX_READY, [1] = TX_BUSY.
- FSM states:
  - INIT_BL: write `BAUD_DIV[7:0]` to 0x0.
  - INIT_BH: write `BAUD_DIV[15:8]` to 0x4. On completion, `init_done` goes to 1 and the FSM enters IDLE.
  - IDLE: when `s_valid`, or (RX option and `!rx_valid`), go to RD_STAT. Otherwise stay.
  - RD_STAT: read 0x8 and capture STATUS.
    - If RX option and STATUS[0] and `!rx_valid`: go to RD_DATA0.
    - Else if `s_valid` and !STATUS[1]: go to WR_DATA.
    - Else: go to GAP.
  - RD_DATA0, then RD_DATA1: two back-to-back reads of 0xC. The first result is discarded, because `uart_mem` returns the received byte on the second DATA read after RX_READY rises. The second result's [7:0] goes to `rx_data` and `rx_valid` is set. Then go to WR_DATA if `s_valid` and the captured !STATUS[1], else go to IDLE.
  - WR_DATA: in the issue cycle, `s_ready` is 1 for exactly one cycle and `s_data` is latched into `m_wdata`. Write 0xC, then go to IDLE.
  - GAP: count `POLL_GAP` cycles, then go to IDLE.
- `rx_valid` is held until `rx_ready`. While it is held, no RX reads are issued; `uart_mem` overrun is not this block's concern.
- On a bus error the transaction counts as complete, `err` is set, and the FSM advances normally. The byte is not resent.

## Timing
- Reset values: every output is 0, `m_addr` is 0, and the FSM is in INIT_BL.
- Transaction protocol:
  - `m_enable`, `m_wr_en`, `m_addr`, `m_be` and `m_wdata` are registered and stay stable until a posedge samples `m_ready` = 1.
  - `m_enable` is 0 in the following cycle.
  - At least one cycle with `m_enable` low separates any two transactions.
- Read data and `m_bus_err` are captured on the posedge where `m_ready` is 1.
- First bus request starts 1 cycle after `rst` deasserts.
- Best-case TX latency from `s_valid` rising in IDLE, for a zero-wait slave: STATUS issue at +1, DATA write issue at +4, `s_ready` at +4.
- Reset asserted mid-transaction: `m_enable` is 0 the next cycle, any pending RX byte is dropped, and the block re-runs init.
- `s_valid` and RX_READY together: RX is served first, then TX in the same poll sequence.

## Configuration
- `UART_STREAM_RX_EN` defined: RX path present, with states RD_DATA0/RD_DATA1 and outputs `rx_data`/`rx_valid` live.
- Undefined: the `rx_*` ports remain, `rx_data` and `rx_valid` are tied to 0, `rx_ready` is ignored, and IDLE leaves only on `s_valid`.

## Structure
- Shared package `uart_pkg` holds:
  - the register offset constants (`UART_BAUD_L_ADDR` … `UART_INT_PENDING_ADDR`);
  - the STATUS bit positions `UART_STAT_RX_READY` = 0 and `UART_STAT_TX_BUSY` = 1;
  - the FSM state enum.
- One sub-module, `uart_bus_txn`, is the single-transaction bus engine. It takes a start pulse plus address, wr_en and data. It returns a done pulse, rdata and err, and owns the enable/ready handshake and the mandatory idle cycle.

## Test plan
- Reset with `BAUD_DIV` = 434 and a zero-wait slave model:
  - writes 0xB2 to 0x0, then 0x01 to 0x4, both with be 4'b0001;
  - `init_done` becomes 1; `err` stays 0.
- `s_data` = 0xAA with `s_valid` held, STATUS returning 0x0:
  - read of 0x8, then write of 0x000000AA to 0xC;
  - one `s_ready` pulse.
- STATUS returns 0x2 three times and then 0x0:
  - exactly 4 STATUS reads, spaced at least `POLL_GAP` cycles apart;
  - a single DATA write.
- RX_EN, STATUS = 0x1, DATA reads return 0x00 then 0x55:
  - `rx_data` = 0x55 and `rx_valid` held until `rx_ready`;
  - no further DATA reads while held.
- Slave asserts `m_bus_err` on the DATA write:
  - `err` is 1 and stays 1 across later transfers;
  - the next byte is still written.
- Loopback of real `uart_mem` (tx_pin to rx_pin) with RX_EN, sending 0xAA:
  - `rx_data` = 0xAA within 16×`BAUD_DIV` cycles;
  - `rst` pulsed mid-write gives `m_enable` = 0 the next cycle, followed by a fresh init.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register map, STATUS bit positions and FSM state type for the
// uart_mem register bus and its stream master.
package uart_pkg;

  localparam int unsigned UART_BAUD_L_ADDR      = 'h00;
  localparam int unsigned UART_BAUD_H_ADDR      = 'h04;
  localparam int unsigned UART_STATUS_ADDR      = 'h08;
  localparam int unsigned UART_DATA_ADDR        = 'h0C;
  localparam int unsigned UART_INT_EN_ADDR      = 'h10;
  localparam int unsigned UART_INT_PENDING_ADDR = 'h14;

  localparam int unsigned UART_STAT_RX_READY = 0;
  localparam int unsigned UART_STAT_TX_BUSY  = 1;

  typedef enum logic [2:0] {
    ST_INIT_BL,
    ST_INIT_BH,
    ST_IDLE,
    ST_RD_STAT,
    ST_RD_DATA0,
    ST_RD_DATA1,
    ST_WR_DATA,
    ST_GAP
  } uart_sm_state_t;

endpackage

// File: rtl/uart_bus_txn.sv
// Single-transaction bus engine: latches a request on start, holds it until
// m_ready, then returns a one-cycle done with captured rdata/err.
module uart_bus_txn #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  err,
  output logic                  m_enable,
  output logic                  m_wr_en,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [3:0]            m_be,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_bus_err
);

  // start is only honoured while m_enable is low, so the cycle after a
  // completion always has m_enable low.
  always_ff @(posedge clk) begin
    if (rst) begin
      done     <= '0;
      rdata    <= '0;
      err      <= '0;
      m_enable <= '0;
      m_wr_en  <= '0;
      m_addr   <= '0;
      m_wdata  <= '0;
      m_be     <= '0;
    end else begin
      done <= '0;
      if (m_enable) begin
        if (m_ready) begin
          m_enable <= '0;
          m_be     <= '0;
          done     <= '1;
          rdata    <= m_rdata;
          err      <= m_bus_err;
        end
      end else if (start) begin
        m_enable <= '1;
        m_wr_en  <= wr_en;
        m_addr   <= addr;
        m_wdata  <= wdata;
        m_be     <= 4'b0001;
      end
    end
  end

endmodule

// File: rtl/uart_stream_master.sv
// Stream-to-uart_mem bus master: programs the baud divisor, then polls STATUS
// and writes stream bytes to DATA. Optional RX drain: define UART_STREAM_RX_EN.
module uart_stream_master #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BASE_ADDR  = 0,
  parameter int unsigned BAUD_DIV   = 434,
  parameter int unsigned POLL_GAP   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            s_data,
  input  logic                  s_valid,
  output logic                  s_ready,
  output logic [7:0]            rx_data,
  output logic                  rx_valid,
  input  logic                  rx_ready,
  output logic                  m_enable,
  output logic                  m_wr_en,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  output logic [3:0]            m_be,
  input  logic                  m_ready,
  input  logic [DATA_WIDTH-1:0] m_rdata,
  input  logic                  m_bus_err,
  output logic                  init_done,
  output logic                  err
);
  import uart_pkg::*;

  localparam logic [7:0]  BAUD_LO  = 8'(BAUD_DIV);
  localparam logic [7:0]  BAUD_HI  = 8'(BAUD_DIV >> 8);
  localparam logic [15:0] GAP_LAST = 16'(POLL_GAP - 1);

  uart_sm_state_t          state;
  logic                    pending;
  logic [15:0]             gap_cnt;
  logic                    start;
  logic                    req_wr;
  logic [ADDR_WIDTH-1:0]   req_off;
  logic [ADDR_WIDTH-1:0]   req_addr;
  logic [7:0]              req_byte;
  logic [DATA_WIDTH-1:0]   req_wdata;
  logic                    done;
  logic                    txn_err;
  logic [DATA_WIDTH-1:0]   rdata;
  logic                    idle_go;
  logic                    unused_bits;

  assign unused_bits = ^{rdata, rx_ready};

`ifdef UART_STREAM_RX_EN
  logic tx_busy_q;
  assign idle_go = s_valid || !rx_valid;
`else
  assign idle_go  = s_valid;
  assign rx_data  = '0;
  assign rx_valid = '0;
`endif

  // Requests are combinational from the registered state so a new transfer
  // launches on the edge that enters (or stays in) its issuing state.
  always_comb begin
    start    = '0;
    req_wr   = '0;
    req_off  = ADDR_WIDTH'(UART_STATUS_ADDR);
    req_byte = '0;
    if (!pending) begin
      case (state)
        ST_INIT_BL: begin
          start    = '1;
          req_wr   = '1;
          req_off  = ADDR_WIDTH'(UART_BAUD_L_ADDR);
          req_byte = BAUD_LO;
        end
        ST_INIT_BH: begin
          start    = '1;
          req_wr   = '1;
          req_off  = ADDR_WIDTH'(UART_BAUD_H_ADDR);
          req_byte = BAUD_HI;
        end
        ST_IDLE: start = idle_go;
        ST_RD_DATA0, ST_RD_DATA1: begin
          start   = '1;
          req_off = ADDR_WIDTH'(UART_DATA_ADDR);
        end
        ST_WR_DATA: begin
          start    = '1;
          req_wr   = '1;
          req_off  = ADDR_WIDTH'(UART_DATA_ADDR);
          req_byte = s_data;
        end
        default: ;
      endcase
    end
    req_addr  = ADDR_WIDTH'(BASE_ADDR) + req_off;
    req_wdata = DATA_WIDTH'(req_byte);
  end

  uart_bus_txn #(
    .ADDR_WIDTH(ADDR_WIDTH),
    .DATA_WIDTH(DATA_WIDTH)
  ) u_txn (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .wr_en    (req_wr),
    .addr     (req_addr),
    .wdata    (req_wdata),
    .done     (done),
    .rdata    (rdata),
    .err      (txn_err),
    .m_enable (m_enable),
    .m_wr_en  (m_wr_en),
    .m_addr   (m_addr),
    .m_wdata  (m_wdata),
    .m_be     (m_be),
    .m_ready  (m_ready),
    .m_rdata  (m_rdata),
    .m_bus_err(m_bus_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_INIT_BL;
      pending   <= '0;
      gap_cnt   <= '0;
      s_ready   <= '0;
      init_done <= '0;
      err       <= '0;
`ifdef UART_STREAM_RX_EN
      rx_data   <= '0;
      rx_valid  <= '0;
      tx_busy_q <= '0;
`endif
    end else begin
      s_ready <= '0;
      if (start) pending <= '1;
      if (done && txn_err) err <= '1;
`ifdef UART_STREAM_RX_EN
      if (rx_valid && rx_ready) rx_valid <= '0;
`endif
      case (state)
        ST_INIT_BL: if (done) begin
          state   <= ST_INIT_BH;
          pending <= '0;
        end
        ST_INIT_BH: if (done) begin
          state     <= ST_IDLE;
          pending   <= '0;
          init_done <= '1;
        end
        ST_IDLE: if (start) state <= ST_RD_STAT;
        ST_RD_STAT: if (done) begin
          pending <= '0;
`ifdef UART_STREAM_RX_EN
          tx_busy_q <= rdata[UART_STAT_TX_BUSY];
          if (rdata[UART_STAT_RX_READY] && !rx_valid) state <= ST_RD_DATA0;
          else
`endif
          if (s_valid && !rdata[UART_STAT_TX_BUSY]) state <= ST_WR_DATA;
          else begin
            state   <= ST_GAP;
            gap_cnt <= '0;
          end
        end
`ifdef UART_STREAM_RX_EN
        ST_RD_DATA0: if (done) begin
          state   <= ST_RD_DATA1;
          pending <= '0;
        end
        ST_RD_DATA1: if (done) begin
          pending  <= '0;
          rx_data  <= rdata[7:0];
          rx_valid <= '1;
          state    <= (s_valid && !tx_busy_q) ? ST_WR_DATA : ST_IDLE;
        end
`endif
        ST_WR_DATA: begin
          if (start) s_ready <= '1;
          if (done) begin
            pending <= '0;
            state   <= ST_IDLE;
          end
        end
        ST_GAP: begin
          if (gap_cnt == GAP_LAST) state <= ST_IDLE;
          else gap_cnt <= gap_cnt + 16'd1;
        end
        default: state <= ST_INIT_BL;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_stream_master.sv
// Self-checking bench for uart_stream_master against a behavioural uart_mem
// bus slave (scripted STATUS/DATA responses, programmable wait states).
module tb_uart_stream_master;

  localparam int unsigned GAP  = 6;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] A_BL = BASE + 32'h0;
  localparam logic [31:0] A_BH = BASE + 32'h4;
  localparam logic [31:0] A_ST = BASE + 32'h8;
  localparam logic [31:0] A_DT = BASE + 32'hC;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready = 1'b0;
  logic        m_enable, m_wr_en;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic        m_ready = 1'b0;
  logic [31:0] m_rdata = '0;
  logic        m_bus_err = 1'b0;
  logic        init_done, err;

  uart_stream_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .BASE_ADDR(32'h1000),
    .BAUD_DIV(434), .POLL_GAP(GAP)
  ) dut (
    .clk(clk), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .m_enable(m_enable), .m_wr_en(m_wr_en), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_be(m_be), .m_ready(m_ready), .m_rdata(m_rdata), .m_bus_err(m_bus_err),
    .init_done(init_done), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    int          cyc;
  } txn_t;

  txn_t        log_q[$];
  logic [31:0] status_q[$];
  logic [31:0] data_q[$];
  int          wait_cfg = 0;
  bit          err_wr = 1'b0;
  int          sr_cnt = 0;

  // Bus slave: everything decided on the falling edge, sampled by the DUT on the rising edge.
  int   wcnt = 0;
  bit   offered = 1'b0;
  bit   in_txn = 1'b0;
  txn_t cur;
  always @(negedge clk) begin
    if (s_ready) sr_cnt++;
    if (offered) begin
      log_q.push_back(cur);
      if (!cur.wr && cur.addr == A_ST && status_q.size() > 0) void'(status_q.pop_front());
      if (!cur.wr && cur.addr == A_DT && data_q.size() > 0) void'(data_q.pop_front());
      offered = 1'b0; in_txn = 1'b0;
      m_ready = 1'b0; m_bus_err = 1'b0; m_rdata = '0;
      check("idle_after_txn", {31'd0, m_enable}, 32'd0);
    end
    if (rst) begin
      in_txn = 1'b0; wcnt = 0;
    end else if (m_enable) begin
      if (!in_txn) begin
        in_txn = 1'b1; wcnt = 0;
        cur = '{m_wr_en, m_addr, m_wdata, m_be, cyc};
        check("be", {28'd0, m_be}, 32'd1);
      end else begin
        check("req_stable", {31'd0, (m_wr_en === cur.wr && m_addr === cur.addr &&
                                     m_wdata === cur.wdata && m_be === cur.be)}, 32'd1);
      end
      if (wcnt >= wait_cfg) begin
        m_ready = 1'b1; offered = 1'b1;
        if (!cur.wr && cur.addr == A_ST) m_rdata = (status_q.size() > 0) ? status_q[0] : 32'd0;
        else if (!cur.wr && cur.addr == A_DT) m_rdata = (data_q.size() > 0) ? data_q[0] : 32'd0;
        else m_rdata = '0;
        m_bus_err = err_wr && cur.wr && (cur.addr == A_DT);
      end else wcnt++;
    end else in_txn = 1'b0;
  end

  function automatic int n_of(input logic wr, input logic [31:0] a);
    int n = 0;
    foreach (log_q[i]) if (log_q[i].wr == wr && log_q[i].addr == a) n++;
    return n;
  endfunction

  task automatic wait_log(input int n, input int budget, input string name);
    int k = 0;
    while (log_q.size() < n && k < budget) begin @(negedge clk); k++; end
    check(name, {31'd0, log_q.size() >= n}, 32'd1);
  endtask

  task automatic wait_wr(input int budget);
    int k = 0;
    while (n_of(1'b1, A_DT) < 1 && k < budget) begin @(negedge clk); k++; end
    check("data_write_seen", {31'd0, n_of(1'b1, A_DT) >= 1}, 32'd1);
  endtask

  // Presents a byte; c0 is the first cycle s_valid is high, hs the s_ready cycle.
  task automatic send_byte(input logic [7:0] d, output int c0, output int hs);
    s_data = d; s_valid = 1'b1; hs = -1; c0 = -1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (c0 < 0) c0 = cyc;
      if (s_ready) begin
        hs = cyc;
        @(posedge clk); #1;
        break;
      end
    end
    s_valid = 1'b0;
    check("s_ready_seen", {31'd0, hs >= 0}, 32'd1);
  endtask

  typedef struct {
    logic [7:0]  d;
    int          busy;
    int          waitc;
    bit          inj_err;
    int          exp_reads;
    logic [31:0] exp_wdata;
    bit          exp_err;
  } vec_t;

  initial begin
    vec_t vecs[6];
    txn_t exp_q[$];
    int   c0, hs, r, prev;
    logic [7:0] d;
    int   busy;

    vecs[0] = '{8'hAA, 0, 0, 1'b0, 1, 32'h0000_00AA, 1'b0};
    vecs[1] = '{8'h3C, 3, 0, 1'b0, 4, 32'h0000_003C, 1'b0};
    vecs[2] = '{8'h5A, 1, 2, 1'b0, 2, 32'h0000_005A, 1'b0};
    vecs[3] = '{8'hC3, 0, 1, 1'b1, 1, 32'h0000_00C3, 1'b1};
    vecs[4] = '{8'h0F, 2, 0, 1'b0, 3, 32'h0000_000F, 1'b1};
    vecs[5] = '{8'hFF, 0, 3, 1'b0, 1, 32'h0000_00FF, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_m_enable", {31'd0, m_enable}, 0);
    check("rst_m_addr", m_addr, 0);
    check("rst_m_wdata", m_wdata, 0);
    check("rst_m_be", {28'd0, m_be}, 0);
    check("rst_outs", {28'd0, s_ready, init_done, err, rx_valid}, 0);
    check("rst_rx_data", {24'd0, rx_data}, 0);

    // Init: two baud writes, first one issued 1 cycle after reset release
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); r = cyc;
    wait_log(2, 200, "init_txns");
    check("init0_cyc", log_q[0].cyc, r + 1);
    check("init0", {log_q[0].wr, log_q[0].addr[30:0]}, {1'b1, A_BL[30:0]});
    check("init0_wdata", log_q[0].wdata, 32'hB2);
    check("init1", {log_q[1].wr, log_q[1].addr[30:0]}, {1'b1, A_BH[30:0]});
    check("init1_wdata", log_q[1].wdata, 32'h01);
    check("init1_be", {28'd0, log_q[1].be}, 1);
    repeat (3) @(negedge clk);
    check("init_done", {31'd0, init_done}, 1);
    check("init_err", {31'd0, err}, 0);
`ifndef UART_STREAM_RX_EN
    repeat (40) @(negedge clk);
    check("no_poll_without_valid", log_q.size(), 2);
`endif

`ifdef UART_STREAM_RX_EN
    // RX drain: STATUS=RX_READY, byte arrives on the second DATA read
    log_q.delete(); status_q = {32'h1}; data_q = {32'h00, 32'h55};
    for (int k = 0; k < 500 && !rx_valid; k++) @(negedge clk);
    check("rx_valid_set", {31'd0, rx_valid}, 1);
    check("rx_data", {24'd0, rx_data}, 32'h55);
    check("rx_data_reads", n_of(1'b0, A_DT), 2);
    repeat (100) @(negedge clk);
    check("rx_valid_held", {31'd0, rx_valid}, 1);
    check("rx_no_more_reads", n_of(1'b0, A_DT), 2);
    @(posedge clk); #1 rx_ready = 1'b1;
    @(posedge clk); #1 rx_ready = 1'b0;
    @(negedge clk);
    check("rx_valid_cleared", {31'd0, rx_valid}, 0);
    data_q.delete();
`else
    // Best-case latency with a zero-wait slave
    log_q.delete(); wait_cfg = 0;
    @(posedge clk); #1;
    send_byte(8'h11, c0, hs);
    wait_wr(200);
    check("lat_status_issue", log_q[0].cyc - c0, 1);
    check("lat_s_ready", hs - c0, 4);
    check("lat_write_issue", log_q[1].cyc - c0, 4);
`endif

    // Table-driven vectors
    foreach (vecs[i]) begin
      log_q.delete(); status_q.delete();
      for (int b = 0; b < vecs[i].busy; b++) status_q.push_back(32'h2);
      wait_cfg = vecs[i].waitc; err_wr = vecs[i].inj_err; sr_cnt = 0;
      @(posedge clk); #1;
      send_byte(vecs[i].d, c0, hs);
      wait_wr(1000);
      err_wr = 1'b0;
      repeat (4) @(negedge clk);
`ifndef UART_STREAM_RX_EN
      check($sformatf("vec%0d_status_reads", i), n_of(1'b0, A_ST), vecs[i].exp_reads);
`endif
      check($sformatf("vec%0d_writes", i), n_of(1'b1, A_DT), 1);
      foreach (log_q[j]) if (log_q[j].wr && log_q[j].addr == A_DT)
        check($sformatf("vec%0d_wdata", i), log_q[j].wdata, vecs[i].exp_wdata);
      check($sformatf("vec%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
      check($sformatf("vec%0d_s_ready_pulses", i), sr_cnt, 1);
      prev = -1;
      foreach (log_q[j]) if (!log_q[j].wr && log_q[j].addr == A_ST) begin
        if (prev >= 0)
          check($sformatf("vec%0d_poll_spacing", i), {31'd0, (log_q[j].cyc - prev) >= GAP}, 1);
        prev = log_q[j].cyc;
      end
    end

    // Randomized bytes against the reference transaction model
    for (int t = 0; t < 12; t++) begin
      d = 8'($urandom_range(0, 255)); busy = $urandom_range(0, 2);
      log_q.delete(); status_q.delete(); exp_q.delete();
      for (int b = 0; b < busy; b++) status_q.push_back(32'h2);
      for (int b = 0; b <= busy; b++) exp_q.push_back('{1'b0, A_ST, 32'd0, 4'd1, 0});
      exp_q.push_back('{1'b1, A_DT, {24'd0, d}, 4'd1, 0});
      wait_cfg = $urandom_range(0, 3);
      @(posedge clk); #1;
      send_byte(d, c0, hs);
      wait_wr(1000);
      repeat (4) @(negedge clk);
`ifndef UART_STREAM_RX_EN
      check($sformatf("rand%0d_len", t), log_q.size(), exp_q.size());
      for (int j = 0; j < exp_q.size() && j < log_q.size(); j++) begin
        check($sformatf("rand%0d_txn%0d_addr", t, j), log_q[j].addr, exp_q[j].addr);
        check($sformatf("rand%0d_txn%0d_wr", t, j), {31'd0, log_q[j].wr}, {31'd0, exp_q[j].wr});
        if (exp_q[j].wr) check($sformatf("rand%0d_txn%0d_wdata", t, j), log_q[j].wdata, exp_q[j].wdata);
      end
`else
      foreach (log_q[j]) if (log_q[j].wr)
        check($sformatf("rand%0d_wdata", t), log_q[j].wdata, exp_q[exp_q.size()-1].wdata);
`endif
      check($sformatf("rand%0d_err_sticky", t), {31'd0, err}, 1);
    end

    // Reset during a stalled DATA write, then a fresh init
    log_q.delete(); status_q.delete(); wait_cfg = 8;
    @(posedge clk); #1;
    send_byte(8'h77, c0, hs);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_inflight", {31'd0, (m_enable && m_wr_en && m_addr == A_DT)}, 1);
    @(negedge clk);
    check("midrst_m_enable", {31'd0, m_enable}, 0);
    check("midrst_init_done", {31'd0, init_done}, 0);
    check("midrst_err", {31'd0, err}, 0);
    wait_cfg = 0;
    @(posedge clk); #1 rst = 1'b0;
    log_q.delete();
    wait_log(2, 200, "reinit_txns");
    check("reinit0_addr", log_q[0].addr, A_BL);
    check("reinit0_wdata", log_q[0].wdata, 32'hB2);
    check("reinit1_addr", log_q[1].addr, A_BH);
    check("reinit1_wdata", log_q[1].wdata, 32'h01);
    repeat (3) @(negedge clk);
    check("reinit_done", {31'd0, init_done}, 1);
`ifndef UART_STREAM_RX_EN
    check("rx_tied_off", {23'd0, rx_valid, rx_data}, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=%0d required=finish", cyc);
    $fatal(1, "timeout");
  end

endmodule
